// File: rtl/dc_fu_dma_ar_burst_issuer.sv
// Fetch-unit DMA read-request side: splits a fetch command into AXI4 INCR AR
// bursts capped at MAX_BURST_LEN beats that never cross a 4 KiB boundary.
module dc_fu_dma_ar_burst_issuer #(
  parameter int ADDR_WIDTH             = 32,
  parameter int FETCH_WORD_COUNT_WIDTH = 16,
  parameter int DATA_BYTES             = 8,
  parameter int MAX_BURST_LEN          = 16
) (
  input  logic                              clk,
  input  logic                              nrst,
  input  logic                              en,
  input  logic                              start_fetch,
  input  logic [ADDR_WIDTH-1:0]             fetch_addr,
  input  logic [FETCH_WORD_COUNT_WIDTH-1:0] fetch_word_count,
  output logic                              busy,
  output logic                              done,
  output logic [ADDR_WIDTH-1:0]             axi_araddr,
  output logic [7:0]                        axi_arlen,
  output logic [2:0]                        axi_arsize,
  output logic [1:0]                        axi_arburst,
  output logic                              axi_arvalid,
  input  logic                              axi_arready
);
  localparam int SZ = $clog2(DATA_BYTES);
  localparam int CW = (FETCH_WORD_COUNT_WIDTH > 13 ? FETCH_WORD_COUNT_WIDTH : 13) + 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(DATA_BYTES - 1);

  typedef enum logic [1:0] {IDLE, PRESENT, WAIT} state_t;

  state_t                            state_r, state_nx;
  logic [ADDR_WIDTH-1:0]             addr_r, araddr_r, cur_addr;
  logic [FETCH_WORD_COUNT_WIDTH-1:0] remaining_r, cur_rem;
  logic [7:0]                        arlen_r;
  logic [8:0]                        len;
  logic                              done_r, done_nx, load_cmd, load_next, hs;

  // min(remaining, MAX_BURST_LEN, beats left before the next 4 KiB boundary)
  function automatic logic [8:0] burst_len(input logic [11:0] off,
                                           input logic [FETCH_WORD_COUNT_WIDTH-1:0] rem);
    logic [12:0]   bnd;
    logic [CW-1:0] m;
    bnd = (13'd4096 - {1'b0, off}) >> SZ;
    m   = CW'(MAX_BURST_LEN);
    if (CW'(bnd) < m) m = CW'(bnd);
    if (CW'(rem) < m) m = CW'(rem);
    return 9'(m);
  endfunction

  // addr_r/remaining_r track the burst after the one currently on AR, so the
  // next payload is ready to register on the handshake edge with no bubble.
  assign cur_addr = load_cmd ? (fetch_addr & ALIGN_MASK) : addr_r;
  assign cur_rem  = load_cmd ? fetch_word_count : remaining_r;
  assign len      = burst_len(cur_addr[11:0], cur_rem);
  assign hs       = axi_arvalid && axi_arready;

  always_comb begin
    state_nx  = state_r;
    done_nx   = 1'b0;
    load_cmd  = 1'b0;
    load_next = 1'b0;
    case (state_r)
      IDLE: if (start_fetch && en) begin
        if (fetch_word_count != '0) begin
          load_cmd = 1'b1;
          state_nx = PRESENT;
        end else begin
          done_nx  = 1'b1;
        end
      end
      PRESENT: if (hs) begin
        if (remaining_r == '0) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else if (en) begin
          load_next = 1'b1;
        end else begin
          state_nx  = WAIT;
        end
      end
      WAIT: if (en) begin
        load_next = 1'b1;
        state_nx  = PRESENT;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_r <= IDLE;
    else       state_r <= state_nx;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      addr_r      <= '0;
      remaining_r <= '0;
      araddr_r    <= '0;
      arlen_r     <= '0;
      done_r      <= 1'b0;
    end else begin
      done_r <= done_nx;
      if (load_cmd || load_next) begin
        araddr_r    <= cur_addr;
        arlen_r     <= 8'(len - 9'd1);
        addr_r      <= cur_addr + (ADDR_WIDTH'(len) << SZ);
        remaining_r <= cur_rem - FETCH_WORD_COUNT_WIDTH'(len);
      end
    end
  end

  assign axi_arvalid = (state_r == PRESENT);
  assign busy        = (state_r != IDLE);
  assign done        = done_r;
  assign axi_araddr  = araddr_r;
  assign axi_arlen   = arlen_r;
  assign axi_arsize  = 3'(SZ);
  assign axi_arburst = 2'b01;

endmodule

// File: tb/tb_dc_fu_dma_ar_burst_issuer.sv
// Bench for the AR burst issuer: directed plan cases plus random traffic checked
// against a queue of expected bursts computed from the split rules.
module tb_dc_fu_dma_ar_burst_issuer;
  logic        clk = 1'b0, nrst = 1'b0, en = 1'b0, start_fetch = 1'b0, axi_arready = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic [15:0] fetch_word_count = '0;
  logic        busy, done, axi_arvalid;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;

  dc_fu_dma_ar_burst_issuer dut (
    .clk(clk), .nrst(nrst), .en(en), .start_fetch(start_fetch),
    .fetch_addr(fetch_addr), .fetch_word_count(fetch_word_count),
    .busy(busy), .done(done), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [7:0] l; } burst_t;
  burst_t      q[$];
  int          checks = 0, errors = 0;
  logic        active = 0, exp_vld = 0, exp_done = 0, hold = 0;
  logic [31:0] h_addr;
  logic [7:0]  h_len;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected bursts for a command, straight from the split rules.
  task automatic gen_bursts(input logic [31:0] addr, input int cnt);
    logic [31:0] a;
    int r, bnd, l;
    a = addr & ~32'd7;
    r = cnt;
    while (r > 0) begin
      bnd = (4096 - int'(a % 4096)) / 8;
      l = r;
      if (l > 16) l = 16;
      if (l > bnd) l = bnd;
      q.push_back('{a: a, l: 8'(l - 1)});
      a = a + 32'(l * 8);
      r = r - l;
    end
  endtask

  // One clock: check what the previous edge should have produced, then predict
  // the effect of the upcoming edge from the currently driven inputs.
  task automatic cyc();
    logic acc, hs, nv, nd;
    burst_t b;
    @(negedge clk);
    chk("arvalid", 32'(axi_arvalid), 32'(exp_vld));
    chk("busy", 32'(busy), 32'(active));
    chk("done", 32'(done), 32'(exp_done));
    if (hold) begin
      chk("hold_addr", axi_araddr, h_addr);
      chk("hold_len", 32'(axi_arlen), 32'(h_len));
    end
    if (axi_arvalid) begin
      chk("arsize", 32'(axi_arsize), 32'd3);
      chk("arburst", 32'(axi_arburst), 32'd1);
    end
    acc = !active && start_fetch && en;
    hs  = axi_arvalid && axi_arready;
    nv = 1'b0; nd = 1'b0; hold = 1'b0;
    if (hs) begin
      if (q.size() == 0) chk("spurious_ar", 32'd1, 32'd0);
      else begin
        b = q.pop_front();
        chk("araddr", axi_araddr, b.a);
        chk("arlen", 32'(axi_arlen), 32'(b.l));
      end
      if (q.size() == 0) begin active = 1'b0; nd = 1'b1; end
      else nv = en;
    end else if (axi_arvalid) begin
      nv = 1'b1; hold = 1'b1; h_addr = axi_araddr; h_len = axi_arlen;
    end else if (active) nv = en;
    if (acc) begin
      if (fetch_word_count == 0) nd = 1'b1;
      else begin
        gen_bursts(fetch_addr, int'(fetch_word_count));
        active = 1'b1; nv = 1'b1;
      end
    end
    exp_vld = nv; exp_done = nd;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (active && n < 300) begin cyc(); n++; end
    chk("drain_timeout", 32'(active), 32'd0);
    cyc();
  endtask

  task automatic run_cmd(input logic [31:0] addr, input int cnt);
    fetch_addr = addr; fetch_word_count = 16'(cnt); start_fetch = 1'b1;
    cyc();
    start_fetch = 1'b0;
    drain();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_vld"}, 32'(axi_arvalid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_addr"}, axi_araddr, 32'd0);
    chk({tag, "_len"}, 32'(axi_arlen), 32'd0);
    chk({tag, "_size"}, 32'(axi_arsize), 32'd3);
    chk({tag, "_burst"}, 32'(axi_arburst), 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("rst");
    nrst = 1'b1; en = 1'b1; axi_arready = 1'b1;
    cyc();

    run_cmd(32'h1000, 10);
    run_cmd(32'h0, 40);
    run_cmd(32'hFF0, 8);
    run_cmd(32'h1FF8, 1);
    run_cmd(32'h1003, 3);
    run_cmd(32'h400, 0);

    // backpressure, then en dropped while the burst is unacknowledged
    axi_arready = 1'b0;
    fetch_addr = 32'h2000; fetch_word_count = 16'd20; start_fetch = 1'b1;
    cyc();
    start_fetch = 1'b0;
    repeat (5) cyc();
    en = 1'b0;
    repeat (2) cyc();
    axi_arready = 1'b1;
    repeat (3) cyc();
    en = 1'b1;
    drain();

    // start_fetch while busy is ignored
    axi_arready = 1'b0;
    fetch_addr = 32'h0; fetch_word_count = 16'd40; start_fetch = 1'b1;
    cyc();
    fetch_addr = 32'h5000; fetch_word_count = 16'd3;
    cyc();
    start_fetch = 1'b0; axi_arready = 1'b1;
    drain();

    // asynchronous reset during the second burst of a 40-word fetch
    fetch_addr = 32'h0; fetch_word_count = 16'd40; start_fetch = 1'b1;
    cyc();
    start_fetch = 1'b0;
    cyc();
    #1 nrst = 1'b0;
    #1 check_reset_outputs("midrst");
    q.delete(); active = 1'b0; exp_vld = 1'b0; exp_done = 1'b0; hold = 1'b0;
    @(posedge clk); #1 nrst = 1'b1;
    run_cmd(32'h200, 4);

    // random traffic, biased toward 4 KiB boundaries
    for (int i = 0; i < 4000; i++) begin
      int r;
      en = ($urandom % 4) != 0;
      axi_arready = ($urandom % 2) != 0;
      start_fetch = ($urandom % 6) == 0;
      r = $urandom % 8;
      fetch_word_count = (r == 0) ? 16'd0 : (r < 6) ? 16'($urandom_range(1, 40))
                                                    : 16'($urandom_range(1, 300));
      fetch_addr = $urandom;
      if ($urandom % 2) fetch_addr[11:0] = 12'(4096 - $urandom_range(1, 256));
      cyc();
    end
    start_fetch = 1'b0; en = 1'b1; axi_arready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
